// File: rtl/ahb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ahb_arbiter
// Description : AHB bus arbiter for five masters. Decodes the round-robin
//               priority vector against the request lines. Registers a
//               one-hot grant. Re-arbitrates only at legal points: never
//               inside a fixed-length burst, and never while a lock is held.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_arbiter #(
  parameter int DEF_MST = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  hbusreq,
  input  logic [4:0]  hlock,
  input  logic [24:0] prio,
  input  logic        hready,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hburst,
  output logic [15:0] hgrantx,
  output logic [3:0]  hmaster,
  output logic        hmastlock
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [4:0] DEF_GRANT = 5'b00001 << DEF_MST;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    BURST = 2'd1,
    LOCK  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [4:0]  grant;
  logic [4:0]  winner;
  logic [2:0]  gidx;
  logic        arb;

  // A slot counts only when it holds exactly one master id.
  function automatic logic is_onehot(input logic [4:0] v);
    return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
  endfunction

  assign hgrantx = {11'd0, grant};

  // Priority decode. Slot 0 is the fallback. Slots 4..1 are scanned so
  // that slot 1 is applied last and therefore wins.
  always_comb begin
    logic [4:0] slot;
    winner = DEF_GRANT;
    slot   = prio[24:20];
    if (is_onehot(slot) && ((slot & hbusreq) != 5'd0)) winner = slot;
    for (int k = 4; k >= 1; k--) begin
      slot = prio[24-5*k -: 5];
      if (is_onehot(slot) && ((slot & hbusreq) != 5'd0)) winner = slot;
    end
  end

  // Index of the currently granted master.
  always_comb begin
    gidx = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (grant[i]) gidx = 3'(i);
    end
  end

  // Next-state logic: decides whether this cycle is an arbitration point.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    arb       = 1'b0;
    case (state)
      ARB: begin
        if (hready) begin
          if ((htrans == HTRANS_NONSEQ) && (hburst[2:1] != 2'b00)) begin
            // A fixed-length burst starts; the grant is frozen for its duration.
            state_nxt = BURST;
            case (hburst[2:1])
              2'b01:   cnt_nxt = 4'd3;
              2'b10:   cnt_nxt = 4'd7;
              default: cnt_nxt = 4'd15;
            endcase
          end else begin
            arb = 1'b1;
          end
        end
      end
      BURST: begin
        if (hready) begin
          case (htrans)
            HTRANS_SEQ: begin
              // The grant moves on the last SEQ so the new owner is ready
              // during the final data phase.
              if (cnt <= 4'd1) arb = 1'b1;
              else             cnt_nxt = cnt - 4'd1;
            end
            HTRANS_IDLE, HTRANS_NONSEQ: arb = 1'b1;
            HTRANS_BUSY: ;
            default: ;
          endcase
        end
      end
      LOCK: begin
        // hmaster trails the grant by one accepted cycle. The lock is
        // released only after ownership has caught up with the grant.
        if (hready && (hmaster[2:0] == gidx) && !hlock[hmaster[2:0]]) arb = 1'b1;
      end
      default: state_nxt = ARB;
    endcase
    if (arb) begin
      cnt_nxt   = 4'd0;
      state_nxt = ((winner & hlock) != 5'd0) ? LOCK : ARB;
    end
  end

  // State, beat counter, grant and bus ownership registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      cnt       <= 4'd0;
      grant     <= DEF_GRANT;
      hmaster   <= 4'(DEF_MST);
      hmastlock <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (arb) grant <= winner;
      if (hready) begin
        hmaster   <= {1'b0, gidx};
        hmastlock <= hlock[gidx];
      end
    end
  end

endmodule
`default_nettype wire
